cache_line_sel_valid: RTL and testbench

Parametrised, registered line-select decoder with a per-line valid-bit array for the cache tag/data path. It decodes an IDX_W-bit set index to a one-hot line select and returns that line's valid status. It services fill (set valid) and invalidate (clear valid) requests, and runs a multi-cycle flush sequencer that clears all valid bits in groups. It sits between the cache controller FSM and the tag/data arrays.

---
 rtl/cache_line_sel_valid_if.sv | 38 +++
 rtl/cache_line_sel_valid.sv | 129 ++++++++++++
 tb/tb_cache_line_sel_valid.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_sel_valid_if.sv
// Bus between the cache controller and the line-select/valid block.
// The valid_cnt signal exists only when CACHE_VALID_CNT_EN is defined.
interface cache_line_sel_valid_if #(
  parameter int unsigned IDX_W = 6
);
  localparam int unsigned LINES = 2 ** IDX_W;

  logic [IDX_W-1:0] idx_in;
  logic             req_en;
  logic             wr_en;
  logic             inval_en;
  logic             flush_req;
  logic [LINES-1:0] sel_out;
  logic             hit_out;
  logic             busy;
  logic             flush_done;
`ifdef CACHE_VALID_CNT_EN
  logic [IDX_W:0]   valid_cnt;
`endif

  // Controller side
  modport master (
    output idx_in, req_en, wr_en, inval_en, flush_req,
`ifdef CACHE_VALID_CNT_EN
    input  valid_cnt,
`endif
    input  sel_out, hit_out, busy, flush_done
  );

  // Line-select/valid block side
  modport slave (
    input  idx_in, req_en, wr_en, inval_en, flush_req,
`ifdef CACHE_VALID_CNT_EN
    output valid_cnt,
`endif
    output sel_out, hit_out, busy, flush_done
  );
endinterface

// File: rtl/cache_line_sel_valid.sv
// Registered set-index decoder with per-line valid bits, fill/invalidate
// and a grouped flush sequencer. Optional valid-line counter enabled by
// defining CACHE_VALID_CNT_EN.
module cache_line_sel_valid #(
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned CLR_PER_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_line_sel_valid_if.slave bus
);
  localparam int unsigned LINES  = 2 ** IDX_W;
  localparam int unsigned GROUPS = LINES / CLR_PER_CYC;
  localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] sel_q, sel_d;
  logic             hit_q, hit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] flush_base;
`ifdef CACHE_VALID_CNT_EN
  logic [IDX_W:0]         vcnt_q, vcnt_d;
  logic [IDX_W:0]         grp_pop;
  logic [CLR_PER_CYC-1:0] grp;
`endif

  // Next-state, valid-array update and lookup decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    flush_base = IDX_W'(32'(cnt_q) * CLR_PER_CYC);
    sel_d      = bus.req_en ? (LINES'(1) << bus.idx_in) : '0;
    hit_d      = bus.req_en && (state_q == IDLE) && valid_q[bus.idx_in];
`ifdef CACHE_VALID_CNT_EN
    vcnt_d  = vcnt_q;
    grp     = valid_q[flush_base +: CLR_PER_CYC];
    grp_pop = '0;
    for (int i = 0; i < int'(CLR_PER_CYC); i++) begin
      grp_pop = grp_pop + (IDX_W+1)'(grp[i]);
    end
`endif

    case (state_q)
      IDLE: begin
        // Invalidate takes priority over fill
        if (bus.inval_en) begin
          valid_d[bus.idx_in] = 1'b0;
`ifdef CACHE_VALID_CNT_EN
          if (valid_q[bus.idx_in]) vcnt_d = vcnt_q - (IDX_W+1)'(1);
`endif
        end else if (bus.wr_en) begin
          valid_d[bus.idx_in] = 1'b1;
`ifdef CACHE_VALID_CNT_EN
          if (!valid_q[bus.idx_in]) vcnt_d = vcnt_q + (IDX_W+1)'(1);
`endif
        end
        if (bus.flush_req) begin
          state_d = FLUSH;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        valid_d[flush_base +: CLR_PER_CYC] = '0;
`ifdef CACHE_VALID_CNT_EN
        vcnt_d = vcnt_q - grp_pop;
`endif
        if (cnt_q == CNT_W'(GROUPS - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, valid array and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      sel_q   <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CACHE_VALID_CNT_EN
      vcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CACHE_VALID_CNT_EN
      vcnt_q  <= vcnt_d;
`endif
    end
  end

  assign bus.sel_out    = sel_q;
  assign bus.hit_out    = hit_q;
  assign bus.busy       = busy_q;
  assign bus.flush_done = done_q;
`ifdef CACHE_VALID_CNT_EN
  assign bus.valid_cnt  = vcnt_q;
`endif
endmodule

// File: tb/tb_cache_line_sel_valid.sv
// Directed bench for cache_line_sel_valid (IDX_W=6, CLR_PER_CYC=8).
// Covers the valid_cnt output when CACHE_VALID_CNT_EN is defined.
module tb_cache_line_sel_valid;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [63:0] exp_sel;

  cache_line_sel_valid_if #(.IDX_W(6)) bus ();

  cache_line_sel_valid #(.IDX_W(6), .CLR_PER_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic wr, input logic inv,
                       input logic fl, input logic [5:0] idx);
    bus.req_en    = req;
    bus.wr_en     = wr;
    bus.inval_en  = inv;
    bus.flush_req = fl;
    bus.idx_in    = idx;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // Reset state
    #23;
    check("rst_sel", bus.sel_out, 64'h0);
    check("rst_hit", 64'(bus.hit_out), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.flush_done), 64'h0);
`ifdef CACHE_VALID_CNT_EN
    check("rst_vcnt", 64'(bus.valid_cnt), 64'h0);
`endif
    rst = 1'b0;
    #1;

    // Sweep every index, nothing valid yet
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 6'(i));
      tick();
      exp_sel = 64'h1 << i;
      check("sweep_sel", bus.sel_out, exp_sel);
      check("sweep_hit", 64'(bus.hit_out), 64'h0);
    end
    check("sel_idx63", bus.sel_out, 64'h8000_0000_0000_0000);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd12);
    tick();
    check("noreq_sel", bus.sel_out, 64'h0);
    check("noreq_hit", 64'(bus.hit_out), 64'h0);

    // Fill 37 with concurrent lookup: old value returned
    drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd37);
    tick();
    check("fill37_nowt", 64'(bus.hit_out), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd37);
    tick();
    check("hit37", 64'(bus.hit_out), 64'h1);
    check("sel37", bus.sel_out, 64'h0000_0020_0000_0000);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd37);
    tick();
    check("inval37_old", 64'(bus.hit_out), 64'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd37);
    tick();
    check("miss37", 64'(bus.hit_out), 64'h0);

    // Fill and invalidate together: invalidate wins
    drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd5);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd5);
    tick();
    check("both5", 64'(bus.hit_out), 64'h0);

    // Fill 0, 9, 63 then flush
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);  tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd9);  tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd63); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd9);
    tick();
    check("hit9_pre", 64'(bus.hit_out), 64'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    tick();
    bus.flush_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check("fl1_busy", 64'(bus.busy), 64'h1);
      check("fl1_done", 64'(bus.flush_done), (c == 9) ? 64'h1 : 64'h0);
      if (c < 9) tick();
    end
    tick();
    check("fl1_end_busy", 64'(bus.busy), 64'h0);
    check("fl1_end_done", 64'(bus.flush_done), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);  tick();
    check("post_fl0", 64'(bus.hit_out), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd9);  tick();
    check("post_fl9", 64'(bus.hit_out), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd63); tick();
    check("post_fl63", 64'(bus.hit_out), 64'h0);

    // Flush with writes, lookups and flush_req held during busy
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd63); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    tick();
    for (int c = 1; c <= 9; c++) begin
      check("fl2_busy", 64'(bus.busy), 64'h1);
      check("fl2_done", 64'(bus.flush_done), (c == 9) ? 64'h1 : 64'h0);
      if (c == 3) begin
        check("fl2_sel63", bus.sel_out, 64'h8000_0000_0000_0000);
        check("fl2_hit63", 64'(bus.hit_out), 64'h0);
      end
      if (c == 4) begin
        check("fl2_sel3", bus.sel_out, 64'h8);
        check("fl2_hit3", 64'(bus.hit_out), 64'h0);
      end
      case (c)
        2:       drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd63);
        3:       drive(1'b1, 1'b1, 1'b0, 1'b1, 6'd3);
        9:       drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        default: drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
      endcase
      if (c < 9) tick();
    end
    tick();
    check("fl2_end_busy", 64'(bus.busy), 64'h0);
    tick();
    check("fl2_noretrig", 64'(bus.busy), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd3);  tick();
    check("fl2_miss3", 64'(bus.hit_out), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd63); tick();
    check("fl2_miss63", 64'(bus.hit_out), 64'h0);

    // Reset in flush cycle 4
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd60); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd1);
    tick(); tick(); tick();
    check("mid_busy_pre", 64'(bus.busy), 64'h1);
    check("mid_sel_pre", bus.sel_out, 64'h2);
    rst = 1'b1;
    #2;
    check("arst_busy", 64'(bus.busy), 64'h0);
    check("arst_sel", bus.sel_out, 64'h0);
    check("arst_hit", 64'(bus.hit_out), 64'h0);
    check("arst_done", 64'(bus.flush_done), 64'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("arst_nopulse", 64'(bus.flush_done), 64'h0);
    end
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd60); tick();
    check("arst_miss60", 64'(bus.hit_out), 64'h0);
    check("arst_busy_post", 64'(bus.busy), 64'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd20); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd20); tick();
    check("arst_hit20", 64'(bus.hit_out), 64'h1);

`ifdef CACHE_VALID_CNT_EN
    check("vcnt_one", 64'(bus.valid_cnt), 64'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd20); tick();
    check("vcnt_zero", 64'(bus.valid_cnt), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd1); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd2); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd3); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd2); tick();
    check("vcnt_three", 64'(bus.valid_cnt), 64'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd2); tick();
    check("vcnt_two", 64'(bus.valid_cnt), 64'd2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd2); tick();
    check("vcnt_redund", 64'(bus.valid_cnt), 64'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd0); tick();
    bus.flush_req = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    check("vcnt_done", 64'(bus.flush_done), 64'h1);
    check("vcnt_flush", 64'(bus.valid_cnt), 64'd0);
`endif

    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
